// File: rtl/basket_line_builder_if.sv
// Handshake and display bus for basket_line_builder.
// The optional total output exists only when BASKET_TOTAL_EN is defined.
interface basket_line_builder_if;
   logic          add_valid;
   logic [16:0]   price;
   logic          add_ready;
   logic          clear;
   logic [1000:0] prices;
   logic [3:0]    count;
   logic          full;
   logic          sat;
`ifdef BASKET_TOTAL_EN
   logic [20:0]   total;
`endif

   modport master (
      output add_valid,
      output price,
      output clear,
      input  add_ready,
      input  prices,
      input  count,
      input  full,
      input  sat
`ifdef BASKET_TOTAL_EN
      ,
      input  total
`endif
   );

   modport slave (
      input  add_valid,
      input  price,
      input  clear,
      output add_ready,
      output prices,
      output count,
      output full,
      output sat
`ifdef BASKET_TOTAL_EN
      ,
      output total
`endif
   );
endinterface

// File: rtl/basket_line_builder.sv
// Accepts item prices, converts each to BCD with a sequential shift-add-3 and renders it as an
// 11-char ASCII line. Define BASKET_TOTAL_EN to add a running total output.
module basket_line_builder (
   input  logic                 CLK,
   input  logic                 RST_N,
   basket_line_builder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

   localparam logic [16:0] PRICE_MAX  = 17'd99999;
   localparam logic [6:0]  SPACE      = 7'h20;
   localparam logic [76:0] BLANK_LINE = {11{SPACE}};
   localparam int          NUM_LINES  = 13;

   state_t      state_reg;
   logic [16:0] bin_reg;
   logic [19:0] bcd_reg;
   logic [4:0]  shift_cnt_reg;
   logic [3:0]  count_reg;
   logic        full_reg;
   logic        ready_reg;
   logic        sat_reg;
   logic [76:0] line_reg [NUM_LINES];

   logic        handshake;
   logic        over_max;
   logic [16:0] clamped;
   logic [15:0] bcd_adj;
   logic [76:0] new_line;
   logic [3:0]  line_num;
   logic [3:0]  line_ones;
   logic [3:0]  d4, d3, d2, d1, d0;

   function automatic logic [6:0] asc(input logic [3:0] d);
      return {3'b011, d};
   endfunction

   assign handshake = bus.add_valid & ready_reg & ~bus.clear;
   assign over_max  = bus.price > PRICE_MAX;
   assign clamped   = over_max ? PRICE_MAX : bus.price;

   // The top digit never reaches 5 before a shift (result is at most 99999), so only
   // the lower four digits need the add-3 correction.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   assign d4 = bcd_reg[19:16];
   assign d3 = bcd_reg[15:12];
   assign d2 = bcd_reg[11:8];
   assign d1 = bcd_reg[7:4];
   assign d0 = bcd_reg[3:0];

   assign line_num  = count_reg + 4'd1;
   assign line_ones = (line_num >= 4'd10) ? line_num - 4'd10 : line_num;

   assign new_line = {
      (line_num >= 4'd10) ? 7'h31 : 7'h30,
      asc(line_ones),
      SPACE,
      SPACE,
      (d4 == 4'd0) ? SPACE : asc(d4),
      ((d4 == 4'd0) && (d3 == 4'd0)) ? SPACE : asc(d3),
      asc(d2),
      7'h2E,
      asc(d1),
      asc(d0),
      7'h54
   };

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg     <= IDLE;
         bin_reg       <= '0;
         bcd_reg       <= '0;
         shift_cnt_reg <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         ready_reg     <= 1'b0;
         sat_reg       <= 1'b0;
      end else if (bus.clear) begin
         state_reg     <= IDLE;
         shift_cnt_reg <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         ready_reg     <= 1'b1;
         sat_reg       <= 1'b0;
      end else begin
         sat_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (handshake) begin
                  bin_reg       <= clamped;
                  bcd_reg       <= '0;
                  shift_cnt_reg <= '0;
                  sat_reg       <= over_max;
                  ready_reg     <= 1'b0;
                  state_reg     <= CONV;
               end else begin
                  ready_reg <= ~full_reg;
               end
            end
            CONV: begin
               bcd_reg       <= {bcd_reg[18:16], bcd_adj, bin_reg[16]};
               bin_reg       <= {bin_reg[15:0], 1'b0};
               shift_cnt_reg <= shift_cnt_reg + 5'd1;
               if (shift_cnt_reg == 5'd16) begin
                  state_reg <= WRITE;
               end
            end
            WRITE: begin
               count_reg <= count_reg + 4'd1;
               full_reg  <= (count_reg == 4'd12);
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Each line only changes on its own WRITE edge or on clear, keeping the text stable for the scanner.
   generate
      for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               line_reg[gi] <= BLANK_LINE;
            end else if (bus.clear) begin
               line_reg[gi] <= BLANK_LINE;
            end else if ((state_reg == WRITE) && (count_reg == 4'(gi))) begin
               line_reg[gi] <= new_line;
            end
         end
         assign bus.prices[1000 - 77*gi -: 77] = line_reg[gi];
      end
   endgenerate

   assign bus.add_ready = ready_reg;
   assign bus.count     = count_reg;
   assign bus.full      = full_reg;
   assign bus.sat       = sat_reg;

`ifdef BASKET_TOTAL_EN
   logic [16:0] price_reg;
   logic [20:0] total_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         price_reg <= '0;
         total_reg <= '0;
      end else if (bus.clear) begin
         total_reg <= '0;
      end else if ((state_reg == IDLE) && handshake) begin
         price_reg <= clamped;
      end else if (state_reg == WRITE) begin
         total_reg <= total_reg + 21'(price_reg);
      end
   end

   assign bus.total = total_reg;
`endif

endmodule

// File: doc/basket_line_builder.md
BASKET_LINE_BUILDER -- requirements
Module: basket_line_builder

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port add_valid, input, 1 bit: an item price is offered this cycle.
REQ-004 SHALL have port price, input, 17 bits: item price in cents, unsigned.
REQ-005 SHALL have port add_ready, output, 1 bit: the block accepts an offered price this cycle.
REQ-006 SHALL have port clear, input, 1 bit: synchronous basket clear.
REQ-007 SHALL have port prices, output, 1001 bits: 13 text lines x 11 chars x 7-bit ASCII, feeding the on-screen price writer.
REQ-008 SHALL have port count, output, 4 bits: number of filled lines, 0..13.
REQ-009 SHALL have port full, output, 1 bit: high when count==13.
REQ-010 SHALL have port sat, output, 1 bit: one-cycle pulse when an accepted price was clamped.

Function
REQ-011 SHALL place line k (0..12) at prices[1000-77k : 924-77k], with char 0 in the top 7 bits of the line.
REQ-012 SHALL format each line as: chars 0-1 line number 01..13 in decimal; chars 2-3 space (0x20); chars 4-6 integer part, leading zeros blanked except char 6; char 7 '.'; chars 8-9 cents; char 10 'T'.
REQ-013 SHALL hold every unfilled line at all-space (0x20 in each char).
REQ-014 SHALL use FSM states IDLE, CONV and WRITE: IDLE->CONV on handshake; CONV->WRITE after 17 shift cycles; WRITE->IDLE after 1 cycle.
REQ-015 SHALL define a handshake as add_valid & add_ready & !clear at a rising edge, and SHALL capture price on that edge.
REQ-016 SHALL drive add_ready (registered) high only in IDLE with full low.
REQ-017 SHALL convert binary to 5 BCD digits by sequential double-dabble, one bit per cycle, over 17 CONV cycles.
REQ-018 SHALL clamp prices above 99999 to 99999 at capture and SHALL pulse sat for the cycle after the capture edge.
REQ-019 SHALL update prices and increment count on the WRITE edge, 18 edges after the handshake edge; add_ready SHALL return high on the following edge if not full.
REQ-020 SHALL ignore add_valid while full; count SHALL NOT wrap past 13.
REQ-021 SHALL give clear priority over all activity: next edge sets all lines to spaces, count=0, state=IDLE and aborts any conversion in progress without writing it.
REQ-022 SHALL not accept an add offered together with clear.
REQ-023 SHALL never change prices other than on WRITE or clear edges, so the downstream scan reads stable text.

Reset
REQ-024 SHALL on RST_N low, immediately and regardless of CLK, set state=IDLE, every char of prices=0x20, count=0, full=0, sat=0 and add_ready=0.
REQ-025 SHALL raise add_ready on the first rising edge after RST_N deasserts.
REQ-026 SHALL abort and discard any conversion in progress when reset is asserted mid-conversion.

Configuration
REQ-027 SHALL, with macro BASKET_TOTAL_EN defined, add output total, 21 bits: running sum of clamped accepted prices in cents. total SHALL update on the WRITE edge, reset to 0 on reset and on clear, and reach at most 1299987.
REQ-028 SHALL, without BASKET_TOTAL_EN, have no total port and no total logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL pass: reset, add price=1234 -> after 18 edges line 0 = "01   12.34T", count=1, add_ready high next cycle.
REQ-030 SHALL pass: add price=5 then price=100 -> line 0 = "01    0.05T", line 1 = "02    1.00T", count=2; with BASKET_TOTAL_EN total=105.
REQ-031 SHALL pass: add price=120000 -> sat pulses once, line shows "999.99", total (if enabled) +=99999.
REQ-032 SHALL pass: 13 adds of 100 -> full=1, add_ready=0; 14th add_valid ignored, line 12 begins "13", count stays 13.
REQ-033 SHALL pass: clear asserted 5 cycles into a conversion -> no line written, all 1001 bits = spaces pattern, count=0, add_ready high next cycle.
REQ-034 SHALL pass: RST_N pulled low between edges mid-WRITE -> outputs reach reset values before the next CLK edge.
